des_ctrl: RTL

- Frame-level transaction controller for the 8-cycle DES serial link.
- Two requesters share the link: port A (instruction fetch, read-only) and port B (load/store, read/write).
- Each frame, the block arbitrates, builds a 32-bit command or data word for des_din, and waits a fixed number of frames for the read response.
- It samples the deserialised response from des_dout and returns it to the granted requester with a single-cycle ack.

---
 rtl/des_pkg.sv | 43 ++++
 rtl/des_rr_arb.sv | 58 +++++
 rtl/des_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES serial-link transaction controller:
// word field widths, op encodings, frame phase markers, FSM state and
// requester identifiers, plus helpers that assemble link words.
package des_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 24;
    localparam int WORD_W = 32;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    // Phase whose closing edge starts a new frame, and the phase whose
    // closing edge captures the deserialised response.
    localparam logic [2:0] FRAME_LAST  = 3'd7;
    localparam logic [2:0] RESP_SAMPLE = 3'd4;

    localparam logic [WORD_W-1:0] NOP_WORD = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic logic [WORD_W-1:0] cmd_word(input logic [1:0]        op,
                                                   input logic [ADDR_W-1:0] addr);
        return {op, addr};
    endfunction

    function automatic logic [WORD_W-1:0] data_word(input logic [DATA_W-1:0] wdata);
        return {8'h00, wdata};
    endfunction

endpackage

// File: rtl/des_rr_arb.sv
// Two-way arbiter for the DES controller. Grant is combinational from the
// live requests; the last-grant register only moves when the controller
// accepts a grant (update). Build option DES_CTRL_FIXED_PRIO_EN switches
// to fixed priority with B always ahead of A; the last-grant register is
// then kept but no longer consulted.
module des_rr_arb
    import des_pkg::*;
(
    input  logic in_clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic gnt_a,
    output logic gnt_b
);

    port_e last_q;
    port_e last_d;

    // Grant selection: contention is resolved against the last winner.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
`ifdef DES_CTRL_FIXED_PRIO_EN
        gnt_b = req_b;
        gnt_a = req_a & ~req_b;
`else
        if (req_a && req_b) begin
            gnt_b = (last_q == PORT_A);
            gnt_a = (last_q == PORT_B);
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
`endif
    end

    // The winner of an accepted grant becomes the last-granted port.
    always_comb begin
        last_d = last_q;
        if (update && gnt_b) begin
            last_d = PORT_B;
        end else if (update && gnt_a) begin
            last_d = PORT_A;
        end
    end

    // Last-grant register; starts at A so B wins the first contention.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_A;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/des_ctrl.sv
// Frame-level transaction controller for the 8-cycle DES serial link.
// Port A issues read-only fetches, port B loads and stores. Each frame the
// controller arbitrates, drives a command/data/NOP word on des_din for the
// whole frame, waits RD_LAT frames for read data and returns it with a
// one-cycle ack. Build option DES_CTRL_FIXED_PRIO_EN (in des_rr_arb)
// selects fixed B-over-A priority instead of round-robin.
module des_ctrl
    import des_pkg::*;
#(
    parameter int RD_LAT = 2  // frames from command frame to response frame, 1..7
) (
    input  logic              in_clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [WORD_W-1:0] des_din,
    input  logic [DATA_W-1:0] des_dout,
    output logic              busy
);

    logic [2:0]        phase_q,   phase_d;
    state_e            state_q,   state_d;
    logic [2:0]        frame_cnt_q, frame_cnt_d;
    port_e             port_q,    port_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [WORD_W-1:0] des_din_q, des_din_d;
    logic              a_ack_q,   a_ack_d;
    logic              b_ack_q,   b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic gnt_a;
    logic gnt_b;
    logic arb_update;
    logic frame_edge;
    logic sample_edge;

    // Acks only ever fire in phase 0 or 5 and grants are taken only on the
    // phase-7 edge, so a request can never be granted alongside its own ack.
    des_rr_arb u_arb (
        .in_clk (in_clk),
        .rst    (rst),
        .req_a  (a_req),
        .req_b  (b_req),
        .update (arb_update),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign frame_edge  = (phase_q == FRAME_LAST);
    assign sample_edge = (phase_q == RESP_SAMPLE);

    // Next-state logic: phase counter, transaction FSM and registered outputs.
    always_comb begin
        // NOTE: every _d takes a default before the case so no branch leaves
        // one unassigned; a missed default here would infer a latch.
        phase_d     = phase_q + 3'd1;
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        des_din_d   = des_din_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        arb_update  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_edge) begin
                    if (gnt_a || gnt_b) begin
                        arb_update = 1'b1;
                        // Transaction fields are frozen here; later requester
                        // changes have no effect on this transaction.
                        if (gnt_b) begin
                            port_d = PORT_B;
                            we_d   = b_we;
                            addr_d = b_addr;
                        end else begin
                            port_d = PORT_A;
                            we_d   = 1'b0;
                            addr_d = a_addr;
                        end
                        wdata_d   = b_wdata;
                        des_din_d = cmd_word(we_d ? OP_WR : OP_RD, addr_d);
                        state_d   = ST_CMD;
                    end else begin
                        des_din_d = NOP_WORD;
                    end
                end
            end

            ST_CMD: begin
                if (frame_edge) begin
                    if (we_q) begin
                        des_din_d = data_word(wdata_q);
                        state_d   = ST_WDATA;
                    end else begin
                        des_din_d   = NOP_WORD;
                        frame_cnt_d = 3'(RD_LAT - 1);
                        state_d     = (RD_LAT == 1) ? ST_RESP : ST_WAIT;
                    end
                end
            end

            ST_WDATA: begin
                // Only port B writes; its ack lands in phase 0 of the NOP frame.
                if (frame_edge) begin
                    des_din_d = NOP_WORD;
                    b_ack_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (frame_edge) begin
                    des_din_d   = NOP_WORD;
                    frame_cnt_d = frame_cnt_q - 3'd1;
                    if (frame_cnt_d == 3'd0) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // Returning to IDLE here lets the same frame's phase-7 edge
                // grant the next transaction, giving back-to-back reads.
                if (sample_edge) begin
                    if (port_q == PORT_B) begin
                        b_rdata_d = des_dout;
                        b_ack_d   = 1'b1;
                    end else begin
                        a_rdata_d = des_dout;
                        a_ack_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            phase_q     <= 3'b111;
            state_q     <= ST_IDLE;
            frame_cnt_q <= 3'd0;
            port_q      <= PORT_A;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            des_din_q   <= NOP_WORD;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            phase_q     <= phase_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            des_din_q   <= des_din_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign des_din = des_din_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
